// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider sequencer driving a shared external ALU (32 ITER steps + FIX).
// Define DIV_SIGNED_EN to enable signed DIV/REM; otherwise all ops are unsigned.
module div_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_carry
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 5;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_ADD = 4'b0010;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            sel_rem_q, sel_rem_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] q_fix, r_fix;
    logic [XLEN-1:0] shifted_r;
    logic            accept;
    logic            unused_funct3;

`ifdef DIV_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;
    logic sgn_a, sgn_b;

    // Signed ops divide magnitudes; signs are reapplied in FIX.
    always_comb begin
        sgn_a = ~funct3[0] & dividend[XLEN-1];
        sgn_b = ~funct3[0] & divisor[XLEN-1];
        mag_a = sgn_a ? (~dividend + XLEN'(1)) : dividend;
        mag_b = sgn_b ? (~divisor + XLEN'(1)) : divisor;
        q_fix = neg_q_q ? (~quo_q + XLEN'(1)) : quo_q;
        r_fix = neg_r_q ? (~rem_q + XLEN'(1)) : rem_q;
    end
    assign unused_funct3 = funct3[2];
`else
    always_comb begin
        mag_a = dividend;
        mag_b = divisor;
        q_fix = quo_q;
        r_fix = rem_q;
    end
    assign unused_funct3 = ^{funct3[2], funct3[0]};
`endif

    // Next-state, datapath step and ALU operand steering.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        result_d  = result_q;
        sel_rem_d = sel_rem_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        alu_data1 = '0;
        alu_data2 = '0;
        alu_ctrl  = ALU_ADD;
        shifted_r = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        accept    = 1'b0;
`ifdef DIV_SIGNED_EN
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    sel_rem_d = funct3[1];
                    count_d   = '0;
                    if (divisor == '0) begin
                        // Zero divisor bypasses ITER; FIX just selects preset Q/R.
                        rem_d   = dividend;
                        quo_d   = '1;
                        dvsr_d  = '0;
                        state_d = S_FIX;
`ifdef DIV_SIGNED_EN
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
`endif
                    end else begin
                        rem_d   = '0;
                        quo_d   = mag_a;
                        dvsr_d  = mag_b;
                        busy_d  = 1'b1;
                        state_d = S_ITER;
`ifdef DIV_SIGNED_EN
                        neg_q_d = sgn_a ^ sgn_b;
                        neg_r_d = sgn_a;
`endif
                    end
                end
            end
            S_ITER: begin
                alu_data1 = shifted_r;
                alu_data2 = dvsr_q;
                alu_ctrl  = ALU_SUB;
                accept    = rem_q[XLEN-1] | ~alu_carry;
                rem_d     = accept ? alu_result : shifted_r;
                quo_d     = {quo_q[XLEN-2:0], accept};
                count_d   = count_q + CW'(1);
                busy_d    = 1'b1;
                if (count_q == CW'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = sel_rem_q ? r_fix : q_fix;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            sel_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            result_q  <= result_d;
            sel_rem_q <= sel_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef DIV_SIGNED_EN
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
